// File: rtl/traffic_intersection_ctrl_pkg.sv
// traffic_pkg: shared state encoding, lamp indices and phase-search helpers for the intersection controller.
package traffic_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_FLASH
    } state_t;

    localparam int LAMP_GREEN  = 0;
    localparam int LAMP_YELLOW = 1;
    localparam int LAMP_RED    = 2;

    function automatic int max_dur(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Cyclic first-set-bit after cur; wraps back to cur itself last, falls back to cur+1.
    function automatic logic [2:0] next_phase(input logic [7:0] dem, input logic [2:0] cur, input int n);
        logic [2:0] nxt;
        logic       hit;
        int         idx;
        nxt = (int'(cur) == n - 1) ? 3'd0 : cur + 3'd1;
        hit = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = int'(cur) + k;
            idx = (idx >= n) ? idx - n : idx;
            if (k <= n && !hit && dem[idx[2:0]]) begin
                nxt = idx[2:0];
                hit = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle pulse every pTICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int pTICK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sec_tick
);

    localparam int CW = $clog2(pTICK_DIV);

    logic [CW-1:0] r_cnt;

    assign o_sec_tick = i_en && (r_cnt == CW'(pTICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_sec_tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: round-robin multi-phase light controller with demand skip and green hold; TRAFFIC_FLASH_EN adds flashing-yellow mode.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int pPHASE_NO   = 4,
    parameter int pTICK_DIV   = 100,
    parameter int pGREEN_SEC  = 14,
    parameter int pYELLOW_SEC = 2,
    parameter int pALLRED_SEC = 1,
    localparam int pCNT_WIDTH = ($clog2(max_dur(pGREEN_SEC, pYELLOW_SEC, pALLRED_SEC)) > 0) ?
                                $clog2(max_dur(pGREEN_SEC, pYELLOW_SEC, pALLRED_SEC)) : 1,
    localparam int PW = $clog2(pPHASE_NO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [pPHASE_NO-1:0]  i_demand,
    input  logic                  i_flash_req,
    output logic [pPHASE_NO-1:0]  o_green,
    output logic [pPHASE_NO-1:0]  o_yellow,
    output logic [pPHASE_NO-1:0]  o_red,
    output logic [PW-1:0]         o_phase_idx,
    output logic [pCNT_WIDTH-1:0] o_countdown,
    output logic                  o_sec_tick
);

    localparam int N  = pPHASE_NO;
    localparam int CW = pCNT_WIDTH;

    logic              w_tick;
    state_t            r_state, w_state;
    logic [PW-1:0]     r_phase, w_phase, w_next;
    logic [CW-1:0]     r_cd, w_cd;
    logic [N-1:0]      r_green, r_yellow, r_red;
    logic [N-1:0]      w_green, w_yellow, w_red, w_self;
    logic [2:0]        w_lamp;
    logic              w_flash_on;

    tick_prescaler #(.pTICK_DIV(pTICK_DIV)) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .o_sec_tick (w_tick)
    );

    assign w_self = N'(1) << r_phase;
    assign w_next = PW'(next_phase(8'(i_demand), 3'(r_phase), pPHASE_NO));

`ifdef TRAFFIC_FLASH_EN
    assign w_flash_on = (r_state != ST_FLASH) ? 1'b1 : (w_tick ? ~r_yellow[0] : r_yellow[0]);
`else
    logic w_unused_flash;
    assign w_unused_flash = i_flash_req;
    assign w_flash_on     = 1'b0;
`endif

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_cd    = r_cd;
        if (w_tick) begin
            if (r_cd != '0)
                w_cd = r_cd - 1'b1;
            else
                case (r_state)
                    ST_GREEN: begin
                        w_state = |(i_demand & ~w_self) ? ST_YELLOW : ST_GREEN;
                        w_cd    = |(i_demand & ~w_self) ? CW'(pYELLOW_SEC - 1) : CW'(pGREEN_SEC - 1);
                    end
                    ST_YELLOW: begin
                        w_state = ST_ALLRED;
                        w_cd    = CW'(pALLRED_SEC - 1);
                    end
                    ST_ALLRED: begin
                        w_state = ST_GREEN;
                        w_phase = w_next;
                        w_cd    = CW'(pGREEN_SEC - 1);
                    end
                    default: ;
                endcase
`ifdef TRAFFIC_FLASH_EN
            if (i_flash_req && r_state != ST_FLASH) begin
                w_state = ST_FLASH;
                w_cd    = '0;
            end else if (!i_flash_req && r_state == ST_FLASH) begin
                w_state = ST_ALLRED;
                w_cd    = CW'(pALLRED_SEC - 1);
            end
`endif
        end
    end

    // Lamps are derived from the next state so they register in step with it.
    always_comb begin
        w_green  = '0;
        w_yellow = '0;
        w_red    = '0;
        w_lamp   = '0;
        for (int i = 0; i < N; i++) begin
            w_lamp = '0;
            if (w_state == ST_FLASH)
                w_lamp[LAMP_YELLOW] = w_flash_on;
            else if (w_state == ST_ALLRED || PW'(i) != w_phase)
                w_lamp[LAMP_RED] = 1'b1;
            else if (w_state == ST_GREEN)
                w_lamp[LAMP_GREEN] = 1'b1;
            else
                w_lamp[LAMP_YELLOW] = 1'b1;
            w_green[i]  = w_lamp[LAMP_GREEN];
            w_yellow[i] = w_lamp[LAMP_YELLOW];
            w_red[i]    = w_lamp[LAMP_RED];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_GREEN;
            r_phase  <= '0;
            r_cd     <= CW'(pGREEN_SEC - 1);
            r_green  <= N'(1);
            r_yellow <= '0;
            r_red    <= ~N'(1);
        end else if (i_en) begin
            r_state  <= w_state;
            r_phase  <= w_phase;
            r_cd     <= w_cd;
            r_green  <= w_green;
            r_yellow <= w_yellow;
            r_red    <= w_red;
        end
    end

    assign o_green     = r_green;
    assign o_yellow    = r_yellow;
    assign o_red       = r_red;
    assign o_phase_idx = r_phase;
    assign o_countdown = r_cd;
    assign o_sec_tick  = w_tick;

    a_no_green_yellow: assert property (@(posedge clk) disable iff (!rst_n) (r_green & r_yellow) == '0);

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Multi-phase intersection controller. It generalises the single-approach traffic light to pPHASE_NO approaches that are served round-robin. Each phase runs GREEN -> YELLOW -> ALL_RED. Demand-based phase skipping, green hold when no conflicting demand, and a seconds countdown for the display decoder are included. The block sits at the top of the traffic subsystem; the countdown feeds the existing 7-segment decoder path.

Parameters:
pPHASE_NO, 4, number of approaches/phases (legal range 2..8)
pTICK_DIV, 100, clk cycles per one-second tick (>=2)
pGREEN_SEC, 14, green duration in seconds (>=1)
pYELLOW_SEC, 2, yellow duration in seconds (>=1)
pALLRED_SEC, 1, all-red clearance in seconds (>=1)
pCNT_WIDTH, $clog2(max(pGREEN_SEC,pYELLOW_SEC,pALLRED_SEC)), countdown width (derived, localparam in practice)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes all state and outputs
demand  in  pPHASE_NO  level request per approach (detector or pedestrian)
flash_req  in  1  request flashing-yellow mode (used only with TRAFFIC_FLASH_EN)
green  out  pPHASE_NO  per-approach green lamp
yellow  out  pPHASE_NO  per-approach yellow lamp
red  out  pPHASE_NO  per-approach red lamp
phase_idx  out  $clog2(pPHASE_NO)  currently served phase
countdown  out  pCNT_WIDTH  seconds remaining in current state minus one
sec_tick  out  1  one-cycle pulse per elapsed second

Behaviour:
- Prescaler: counts 0..pTICK_DIV-1 while en=1. sec_tick=1 in the cycle the count equals pTICK_DIV-1, then the count wraps to 0.
- Each state loads countdown with its duration-1 on entry. countdown decrements on each sec_tick. A sec_tick while countdown==0 causes the transition. Every state therefore lasts exactly duration*pTICK_DIV enabled cycles.
- States (shared enum): ST_GREEN, ST_YELLOW, ST_ALLRED, ST_FLASH.
- ST_GREEN expiry: if any demand bit other than phase_idx is set -> ST_YELLOW. Otherwise reload countdown=pGREEN_SEC-1 and stay in ST_GREEN (green hold).
- ST_YELLOW expiry -> ST_ALLRED.
- ST_ALLRED expiry -> ST_GREEN. phase_idx becomes the first index cyclically after the current one with demand set. If no bit is set, it becomes (phase_idx+1) mod pPHASE_NO (fixed-time fallback).
- demand is sampled only in the cycle of the transition decision. It is not latched.
- Lamp outputs are registered and strictly one-hot per approach:
  - Only approach phase_idx may show green or yellow.
  - All other approaches show red.
  - In ST_ALLRED every approach shows red.
  - green & yellow is never 1 on the same approach; an assertion checks this.
- Reset values: state ST_GREEN, phase_idx=0, countdown=pGREEN_SEC-1, prescaler=0, green=1 (bit 0 only), yellow=0, red=all ones except bit 0, sec_tick=0.
- en=0: prescaler, countdown, FSM and lamps hold their values; sec_tick=0. Resuming continues mid-second without loss.
- Async reset mid-state forces the reset values immediately and independently of clk.
- phase_idx wraps pPHASE_NO-1 -> 0. Non-power-of-2 pPHASE_NO never yields an out-of-range index.

Optional Feature:
Macro TRAFFIC_FLASH_EN.
- Defined:
  - flash_req is sampled at the next sec_tick in any state. If set, the FSM goes to ST_FLASH.
  - In ST_FLASH all yellow bits toggle together on every sec_tick (starting with all on), and green=red=0.
  - When flash_req drops, the exit happens on the next sec_tick: ST_ALLRED with countdown=pALLRED_SEC-1, then normal sequencing from the phase chosen by the ALL_RED rule.
- Undefined: flash_req is ignored, ST_FLASH is unreachable, and no flash logic is synthesised.

Decomposition:
- Package traffic_pkg holds:
  - the state enum typedef
  - state encoding width
  - a max-duration helper function used for pCNT_WIDTH
  - lamp index constants
- One natural sub-module: tick_prescaler (clk, rst_n, en -> sec_tick). It is also reusable by the display path.
- The next-phase priority search (cyclic first-set-bit) is a function in traffic_pkg.

Test Plan:
- Reset and fixed-time run: pPHASE_NO=4, pTICK_DIV=4, demand=4'b1111. Expected: green[0] for 56 cycles, yellow[0] for 8, all red for 4, then green[1]. Order 0->1->2->3->0. countdown steps 13..0 on green.
- Phase skip: demand=4'b1001 during phase 0 green. Expected after ALL_RED: phase_idx=3; phases 1 and 2 are never green.
- Green hold: demand=4'b0001 only. Expected: phase 0 stays green across 3 expiries and countdown reloads to 13. Then assert demand[2]; expected: yellow on the next expiry, then phase_idx=2.
- Enable freeze: drop en for 37 cycles mid-yellow. Expected: lamps, countdown and prescaler unchanged, no sec_tick. Total yellow length is still 8 enabled cycles.
- Async reset: assert rst_n=0 mid-ALL_RED between clk edges. Expected: outputs immediately show reset values (green[0]=1, countdown=13).
- TRAFFIC_FLASH_EN: assert flash_req during phase 2 green. Expected: ST_FLASH on the next sec_tick, yellow=4'b1111/4'b0000 alternating per second. Release flash_req; expected: ALL_RED for 4 cycles, then the next demanded phase goes green.
